// File: rtl/sdram_access_arbiter.sv
// Round-robin arbiter sharing one SDRAM port between a pixel-fetch reader and a writeback writer.
// Reads wait for the SDRAM return with a bounded timeout; writes complete in a single issue cycle.
module sdram_access_arbiter #(
  parameter int ADDR_W         = 26,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_done,
  output logic              sdram_read_en,
  output logic              sdram_write_en,
  output logic [ADDR_W-1:0] address_sdram,
  output logic [DATA_W-1:0] writeData_sdram,
  input  logic [DATA_W-1:0] data_sdram,
  input  logic              sdram_datareadvalid,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  logic              read_en_q, read_en_d;
  logic              write_en_q, write_en_d;
  logic              wr_done_q, wr_done_d;
  logic              busy_q, busy_d;
  logic              rd_win, wr_win;

  // last_grant_q high means the writer won last, so the reader takes the next tie
  always_comb begin
    rd_win = 1'b0;
    wr_win = 1'b0;
    if (state_q == IDLE && enable && !rst) begin
      if (rd_req && (!wr_req || last_grant_q)) rd_win = 1'b1;
      else if (wr_req)                        wr_win = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    rd_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_win) begin
          state_d      = RD_ISSUE;
          addr_d       = rd_addr;
          last_grant_d = 1'b0;
        end else if (wr_win) begin
          state_d      = WR_ISSUE;
          addr_d       = wr_addr;
          wdata_d      = wr_data;
          last_grant_d = 1'b1;
        end
      end
      RD_ISSUE: begin
        state_d = RD_WAIT;
        cnt_d   = '0;
      end
      RD_WAIT: begin
        if (sdram_datareadvalid) begin
          rd_data_d  = data_sdram;
          rd_valid_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == TIMEOUT_VAL) begin
            rd_err_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      WR_ISSUE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    read_en_d  = (state_d == RD_ISSUE);
    write_en_d = (state_d == WR_ISSUE);
    wr_done_d  = (state_d == WR_ISSUE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_err_q     <= 1'b0;
      read_en_q    <= 1'b0;
      write_en_q   <= 1'b0;
      wr_done_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_err_q     <= rd_err_d;
      read_en_q    <= read_en_d;
      write_en_q   <= write_en_d;
      wr_done_q    <= wr_done_d;
      busy_q       <= busy_d;
    end
  end

  assign rd_ack          = rd_win;
  assign wr_ack          = wr_win;
  assign rd_valid        = rd_valid_q;
  assign rd_data         = rd_data_q;
  assign rd_err          = rd_err_q;
  assign wr_done         = wr_done_q;
  assign sdram_read_en   = read_en_q;
  assign sdram_write_en  = write_en_q;
  assign address_sdram   = addr_q;
  assign writeData_sdram = wdata_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Directed self-checking bench for sdram_access_arbiter (TIMEOUT_CYCLES=4).
// Covers reset, single read, stray valids, timeout, enable gating, round-robin ties and reset mid-read.
module tb_sdram_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        rd_req;
  logic [25:0] rd_addr;
  logic        rd_ack;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        wr_req;
  logic [25:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        wr_done;
  logic        sdram_read_en;
  logic        sdram_write_en;
  logic [25:0] address_sdram;
  logic [31:0] writeData_sdram;
  logic [31:0] data_sdram;
  logic        sdram_datareadvalid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sdram_access_arbiter #(
    .ADDR_W(26),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_ack(rd_ack),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .rd_err(rd_err),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ack(wr_ack),
    .wr_done(wr_done),
    .sdram_read_en(sdram_read_en),
    .sdram_write_en(sdram_write_en),
    .address_sdram(address_sdram),
    .writeData_sdram(writeData_sdram),
    .data_sdram(data_sdram),
    .sdram_datareadvalid(sdram_datareadvalid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rreq, input logic [25:0] raddr,
                               input logic wreq, input logic [25:0] waddr, input logic [31:0] wdata,
                               input logic dvalid, input logic [31:0] ddata);
    enable              = en;
    rd_req              = rreq;
    rd_addr             = raddr;
    wr_req              = wreq;
    wr_addr             = waddr;
    wr_data             = wdata;
    sdram_datareadvalid = dvalid;
    data_sdram          = ddata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state with a read already requested: no ack may leak out
    rst = 1'b1;
    applyStimulus(1, 1, 26'h10, 0, 26'h0, 32'h0, 0, 32'h0);
    checkOutput("rst_rd_ack", 32'(rd_ack), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_addr", 32'(address_sdram), 32'd0);
    checkOutput("rst_wdata", writeData_sdram, 32'd0);
    checkOutput("rst_rd_data", rd_data, 32'd0);
    checkOutput("rst_read_en", 32'(sdram_read_en), 32'd0);
    tick();
    rst = 1'b0;
    #1;

    // Single read, data returned on the first RD_WAIT cycle
    checkOutput("rd_ack_grant", 32'(rd_ack), 32'd1);
    checkOutput("wr_ack_idle", 32'(wr_ack), 32'd0);
    tick();
    applyStimulus(1, 0, 26'h10, 0, 26'h0, 32'h0, 0, 32'h0);
    checkOutput("rd_issue_en", 32'(sdram_read_en), 32'd1);
    checkOutput("rd_issue_addr", 32'(address_sdram), 32'h10);
    checkOutput("rd_issue_busy", 32'(busy), 32'd1);
    checkOutput("rd_issue_ack", 32'(rd_ack), 32'd0);
    tick();
    applyStimulus(1, 0, 26'h10, 0, 26'h0, 32'h0, 1, 32'hFF102030);
    checkOutput("rd_wait_en", 32'(sdram_read_en), 32'd0);
    checkOutput("rd_wait_addr", 32'(address_sdram), 32'h10);
    checkOutput("rd_wait_valid", 32'(rd_valid), 32'd0);
    tick();
    applyStimulus(1, 0, 26'h0, 0, 26'h0, 32'h0, 0, 32'h0);
    checkOutput("rd_valid_pulse", 32'(rd_valid), 32'd1);
    checkOutput("rd_data_ret", rd_data, 32'hFF102030);
    checkOutput("rd_done_busy", 32'(busy), 32'd0);
    checkOutput("rd_done_err", 32'(rd_err), 32'd0);
    tick();
    checkOutput("rd_valid_end", 32'(rd_valid), 32'd0);
    checkOutput("rd_data_hold", rd_data, 32'hFF102030);

    // Stray valids in IDLE and RD_ISSUE are ignored
    applyStimulus(1, 0, 26'h0, 0, 26'h0, 32'h0, 1, 32'hDEADBEEF);
    tick();
    checkOutput("stray_idle_valid", 32'(rd_valid), 32'd0);
    checkOutput("stray_idle_data", rd_data, 32'hFF102030);
    applyStimulus(1, 1, 26'h44, 0, 26'h0, 32'h0, 1, 32'hDEADBEEF);
    checkOutput("stray_rd_ack", 32'(rd_ack), 32'd1);
    tick();
    applyStimulus(1, 0, 26'h44, 0, 26'h0, 32'h0, 1, 32'hCAFEF00D);
    tick();
    checkOutput("stray_issue_valid", 32'(rd_valid), 32'd0);
    checkOutput("stray_issue_data", rd_data, 32'hFF102030);
    checkOutput("stray_wait_busy", 32'(busy), 32'd1);
    applyStimulus(1, 0, 26'h44, 0, 26'h0, 32'h0, 1, 32'h12345678);
    tick();
    checkOutput("stray_real_valid", 32'(rd_valid), 32'd1);
    checkOutput("stray_real_data", rd_data, 32'h12345678);

    // Timeout after four RD_WAIT cycles without a return
    applyStimulus(1, 1, 26'h80, 0, 26'h0, 32'h0, 0, 32'h0);
    checkOutput("to_rd_ack", 32'(rd_ack), 32'd1);
    tick();
    applyStimulus(1, 0, 26'h80, 0, 26'h0, 32'h0, 0, 32'h0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("to_wait%0d_err", i), 32'(rd_err), 32'd0);
      checkOutput($sformatf("to_wait%0d_busy", i), 32'(busy), 32'd1);
      tick();
    end
    checkOutput("to_err_pulse", 32'(rd_err), 32'd1);
    checkOutput("to_no_valid", 32'(rd_valid), 32'd0);
    checkOutput("to_idle", 32'(busy), 32'd0);
    checkOutput("to_data_hold", rd_data, 32'h12345678);
    applyStimulus(1, 0, 26'h0, 1, 26'h99, 32'h55, 0, 32'h0);
    checkOutput("to_next_wr_ack", 32'(wr_ack), 32'd1);
    checkOutput("to_next_rd_ack", 32'(rd_ack), 32'd0);
    tick();
    applyStimulus(1, 0, 26'h0, 0, 26'h99, 32'h55, 0, 32'h0);
    checkOutput("wr_issue_en", 32'(sdram_write_en), 32'd1);
    checkOutput("wr_issue_done", 32'(wr_done), 32'd1);
    checkOutput("wr_issue_rd_en", 32'(sdram_read_en), 32'd0);
    checkOutput("wr_issue_addr", 32'(address_sdram), 32'h99);
    checkOutput("wr_issue_data", writeData_sdram, 32'h55);
    checkOutput("wr_err_clear", 32'(rd_err), 32'd0);
    tick();
    checkOutput("wr_end_en", 32'(sdram_write_en), 32'd0);
    checkOutput("wr_end_done", 32'(wr_done), 32'd0);
    checkOutput("wr_addr_hold", 32'(address_sdram), 32'h99);
    checkOutput("wr_data_hold", writeData_sdram, 32'h55);

    // Dropping enable mid-read lets the read finish but blocks the pending write
    applyStimulus(1, 1, 26'h30, 0, 26'h0, 32'h0, 0, 32'h0);
    checkOutput("en_rd_ack", 32'(rd_ack), 32'd1);
    tick();
    applyStimulus(0, 0, 26'h30, 1, 26'h31, 32'h77, 0, 32'h0);
    checkOutput("en_issue_wr_ack", 32'(wr_ack), 32'd0);
    tick();
    applyStimulus(0, 0, 26'h30, 1, 26'h31, 32'h77, 1, 32'hAABBCCDD);
    tick();
    applyStimulus(0, 0, 26'h30, 1, 26'h31, 32'h77, 0, 32'h0);
    checkOutput("en_rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("en_rd_data", rd_data, 32'hAABBCCDD);
    checkOutput("en_blocked_ack", 32'(wr_ack), 32'd0);
    tick();
    checkOutput("en_blocked_ack2", 32'(wr_ack), 32'd0);
    checkOutput("en_blocked_busy", 32'(busy), 32'd0);
    applyStimulus(1, 0, 26'h30, 1, 26'h31, 32'h77, 0, 32'h0);
    checkOutput("en_wr_ack", 32'(wr_ack), 32'd1);
    tick();
    applyStimulus(1, 0, 26'h30, 0, 26'h31, 32'h77, 0, 32'h0);
    checkOutput("en_wr_en", 32'(sdram_write_en), 32'd1);
    checkOutput("en_wr_addr", 32'(address_sdram), 32'h31);
    checkOutput("en_wr_data", writeData_sdram, 32'h77);
    tick();

    // Both requesters held from reset: read, write, read, write
    rst = 1'b1;
    applyStimulus(1, 1, 26'h100, 1, 26'h200, 32'h0BADCAFE, 0, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      logic expRead;
      expRead = (k % 2 == 0);
      checkOutput($sformatf("tie%0d_rd_ack", k), 32'(rd_ack), 32'(expRead));
      checkOutput($sformatf("tie%0d_wr_ack", k), 32'(wr_ack), 32'(!expRead));
      if (expRead) begin
        tick();
        checkOutput($sformatf("tie%0d_rd_en", k), 32'(sdram_read_en), 32'd1);
        checkOutput($sformatf("tie%0d_rd_addr", k), 32'(address_sdram), 32'h100);
        tick();
        applyStimulus(1, 1, 26'h100, 1, 26'h200, 32'h0BADCAFE, 1, 32'(k));
        tick();
        applyStimulus(1, 1, 26'h100, 1, 26'h200, 32'h0BADCAFE, 0, 32'h0);
        checkOutput($sformatf("tie%0d_rd_valid", k), 32'(rd_valid), 32'd1);
      end else begin
        tick();
        checkOutput($sformatf("tie%0d_wr_en", k), 32'(sdram_write_en), 32'd1);
        checkOutput($sformatf("tie%0d_wr_rd_en", k), 32'(sdram_read_en), 32'd0);
        checkOutput($sformatf("tie%0d_wr_addr", k), 32'(address_sdram), 32'h200);
        checkOutput($sformatf("tie%0d_wr_data", k), writeData_sdram, 32'h0BADCAFE);
        checkOutput($sformatf("tie%0d_wr_done", k), 32'(wr_done), 32'd1);
        tick();
      end
    end

    // Reset during RD_WAIT aborts the read silently
    applyStimulus(1, 1, 26'h300, 0, 26'h0, 32'h0, 0, 32'h0);
    checkOutput("mid_rd_ack", 32'(rd_ack), 32'd1);
    tick();
    applyStimulus(1, 0, 26'h300, 0, 26'h0, 32'h0, 0, 32'h0);
    tick();
    checkOutput("mid_wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_addr", 32'(address_sdram), 32'd0);
    checkOutput("mid_rst_rd_data", rd_data, 32'd0);
    checkOutput("mid_rst_read_en", 32'(sdram_read_en), 32'd0);
    checkOutput("mid_rst_valid", 32'(rd_valid), 32'd0);
    applyStimulus(1, 0, 26'h300, 0, 26'h0, 32'h0, 1, 32'hFFFFFFFF);
    tick();
    rst = 1'b0;
    applyStimulus(1, 0, 26'h0, 0, 26'h0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("post_rst%0d_valid", i), 32'(rd_valid), 32'd0);
      checkOutput($sformatf("post_rst%0d_err", i), 32'(rd_err), 32'd0);
      checkOutput($sformatf("post_rst%0d_busy", i), 32'(busy), 32'd0);
    end
    checkOutput("post_rst_rd_data", rd_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_access_arbiter.md
SDRAM_ACCESS_ARBITER -- requirements
Module: sdram_access_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 26, SDRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, pixel word width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, max RD_WAIT cycles before a read is abandoned.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port enable  input  1  permits new grants (driven from startControlRegister).
REQ-007 SHALL have ports rd_req input 1, rd_addr input ADDR_W  pixel-fetch request and address.
REQ-008 SHALL have ports rd_ack output 1, rd_valid output 1, rd_data output DATA_W, rd_err output 1  fetch grant, data return, timeout.
REQ-009 SHALL have ports wr_req input 1, wr_addr input ADDR_W, wr_data input DATA_W  writeback request.
REQ-010 SHALL have ports wr_ack output 1, wr_done output 1  writeback grant, completion.
REQ-011 SHALL have ports sdram_read_en output 1, sdram_write_en output 1, address_sdram output ADDR_W, writeData_sdram output DATA_W  SDRAM command side.
REQ-012 SHALL have ports data_sdram input DATA_W, sdram_datareadvalid input 1  SDRAM read return.
REQ-013 SHALL have port busy  output 1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE.
REQ-015 IDLE: if enable=1 and any request pending, SHALL grant one requester: rd_ack or wr_ack high combinationally that cycle (never both), latch its address (and wr_data), move to RD_ISSUE or WR_ISSUE.
REQ-016 Arbitration SHALL be round-robin via a last_grant bit: lone requester always wins; both pending -> requester not granted last wins; last_grant updated on every grant.
REQ-017 enable=0 SHALL block new grants only; a transaction in flight SHALL complete normally.
REQ-018 RD_ISSUE: sdram_read_en=1 for exactly one cycle, address_sdram=latched rd address; next state RD_WAIT.
REQ-019 RD_WAIT: sdram_read_en=0, address_sdram held; on sdram_datareadvalid=1 capture data_sdram into rd_data, pulse rd_valid one cycle on the following cycle, return to IDLE.
REQ-020 sdram_datareadvalid outside RD_WAIT SHALL be ignored (no rd_valid, no data capture).
REQ-021 RD_WAIT timeout counter SHALL clear on entry, increment each cycle without valid; when it reaches TIMEOUT_CYCLES, SHALL pulse rd_err one cycle, leave rd_data unchanged, return to IDLE.
REQ-022 WR_ISSUE: sdram_write_en=1 for exactly one cycle with address_sdram/writeData_sdram = latched values; wr_done high in that same cycle; next state IDLE.
REQ-023 Minimum latency: read grant to rd_valid = 3 cycles (datareadvalid on first RD_WAIT cycle); write grant to wr_done = 1 cycle.
REQ-024 sdram_read_en and sdram_write_en SHALL never be high in the same cycle.
REQ-025 address_sdram and writeData_sdram SHALL hold last issued values between transactions.
REQ-026 rd_data SHALL hold last returned word until next valid return.
REQ-027 Requests SHALL be level-sensitive; requester holds req until ack; req withdrawn before ack is simply not granted.
REQ-028 Back-to-back: from IDLE a new grant SHALL occur the cycle after the previous transaction returns to IDLE (one IDLE cycle minimum between transactions).

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, last_grant=write (read wins first tie), counter=0, all 1-bit outputs 0, address_sdram=0, writeData_sdram=0, rd_data=0.
REQ-030 rst asserted mid-transaction SHALL abort it with no rd_valid/rd_err/wr_done pulse; operation resumes from IDLE the first edge after release.

Verification
REQ-031 Single read: enable=1, rd_req, rd_addr=0x000010; datareadvalid with data_sdram=0xFF102030 on first RD_WAIT cycle -> read_en pulse 1 cycle at 0x000010, rd_valid 3 cycles after ack, rd_data=0xFF102030.
REQ-032 Tie: rd_req and wr_req held from reset -> order read, write, read, write; write carries wr_addr/wr_data on address_sdram/writeData_sdram with write_en 1 cycle.
REQ-033 Timeout: TIMEOUT_CYCLES=4, read with no datareadvalid -> rd_err pulse after 4 RD_WAIT cycles, rd_valid never, FSM IDLE, next request granted.
REQ-034 Stray valid: datareadvalid pulsed during IDLE and RD_ISSUE -> rd_valid stays 0, rd_data unchanged.
REQ-035 enable low: drop enable during RD_WAIT -> read completes; pending wr_req not acked until enable=1.
REQ-036 Reset mid-read: assert rst in RD_WAIT -> all outputs 0 immediately, no rd_valid after release, busy=0.
